// File: rtl/unidad_busqueda.sv
// Instruction-fetch stage: program counter plus a small synchronous
// instruction memory, issuing words to the datapath over valid/ready and
// stopping when the halt word is fetched.
module unidad_busqueda #(
  parameter int             IW        = 20,
  parameter int             AW        = 5,
  parameter logic [IW-1:0]  HALT_WORD = '0,
  parameter int             CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          instr_ready,
  output logic [IW-1:0] instruccion,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [CW-1:0] instr_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] mem [2**AW];
  logic [IW-1:0] word;
  logic          word_ok;
  logic          idle_like;
  logic          accept;
  logic [AW-1:0] rd_addr;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign idle_like = (state == IDLE) || (state == HALT);
  // In ISSUE instr_valid is always 1, so ready there is a real handshake.
  assign accept    = (state == ISSUE) && instr_ready;
  // On an accepted issue the next word is prefetched at pc+1 so that FETCH
  // only needs one cycle; otherwise the memory tracks the current pc.
  assign rd_addr   = accept ? pc + AW'(1) : pc;

  // Program memory: writes only while stopped, one-cycle registered read.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like) begin
      mem[prog_addr] <= prog_data;
    end
    word <= mem[rd_addr];
  end

  // Fetch/issue control FSM with program counter and issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instruccion <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
      word_ok     <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= FETCH;
            pc          <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
            // word still holds the old address; wait one read for pc=0.
            word_ok     <= 1'b0;
          end
        end
        FETCH: begin
          if (!word_ok) begin
            word_ok <= 1'b1;
          end else if (word == HALT_WORD) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            instruccion <= word;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            pc          <= pc + AW'(1);
            instr_count <= sat_inc(instr_count);
            word_ok     <= 1'b1;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
